elevator_scheduler: RTL



---
 rtl/elevator_scheduler.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/elevator_scheduler.sv
// SCAN-policy elevator sequencer: latches hall/car calls per floor and
// steps the car between floors, opening the door at served floors.
module elevator_scheduler #(
    parameter int NUM_FLOORS  = 8,
    parameter int MOVE_CYCLES = 50000000,
    parameter int DOOR_CYCLES = 100000000
) (
    input  logic                  clk,
    input  logic                  resetBtn_n,
    input  logic [2:0]            req_floor,
    input  logic                  req_up,
    input  logic                  req_down,
    input  logic                  req_in,
    output logic [2:0]            current_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    localparam logic [2:0]  TOP     = 3'(NUM_FLOORS - 1);
    localparam logic [31:0] MOVE_LD = 32'(MOVE_CYCLES);
    localparam logic [31:0] DOOR_LD = 32'(DOOR_CYCLES);

    state_t                  state;
    logic                    dir;
    logic [31:0]             timer;
    logic [NUM_FLOORS-1:0]   up_calls;
    logic [NUM_FLOORS-1:0]   dn_calls;
    logic [NUM_FLOORS-1:0]   car_calls;

    logic                    req_ok;
    logic                    up_ok;
    logic                    dn_ok;
    logic                    in_ok;
    logic                    here_req;
    logic [NUM_FLOORS-1:0]   req_sel;
    logic [NUM_FLOORS-1:0]   set_up;
    logic [NUM_FLOORS-1:0]   set_dn;
    logic [NUM_FLOORS-1:0]   set_car;

    logic [2:0]              nxt_floor;
    logic [NUM_FLOORS-1:0]   sel_cur;
    logic [NUM_FLOORS-1:0]   sel_nxt;
    logic [NUM_FLOORS-1:0]   gt_cur;
    logic [NUM_FLOORS-1:0]   lt_cur;
    logic [NUM_FLOORS-1:0]   gt_nxt;
    logic [NUM_FLOORS-1:0]   lt_nxt;

    logic                    here_cur;
    logic                    above_cur;
    logic                    below_cur;
    logic                    above_nxt;
    logic                    below_nxt;
    logic                    tick;
    logic                    stop_up;
    logic                    stop_dn;
    logic                    go_up;
    logic                    go_dn;

    logic [NUM_FLOORS-1:0]   clr_up;
    logic [NUM_FLOORS-1:0]   clr_dn;
    logic [NUM_FLOORS-1:0]   clr_car;

    assign pending     = up_calls | dn_calls | car_calls;
    assign moving_up   = (state == MOVE_UP);
    assign moving_down = (state == MOVE_DOWN);
    assign door_open   = (state == DOOR_OPEN);
    assign busy        = (state != IDLE);

    // Filter incoming strobes; a call for the open-door floor only holds the door
    always_comb begin
        req_ok   = int'(req_floor) < NUM_FLOORS;
        up_ok    = req_up && req_ok && (req_floor != TOP);
        dn_ok    = req_down && req_ok && (req_floor != 3'd0);
        in_ok    = req_in && req_ok;
        here_req = (state == DOOR_OPEN) && (req_floor == current_floor)
                   && (up_ok || dn_ok || in_ok);
        req_sel  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            req_sel[i] = (3'(i) == req_floor);
        end
        set_up  = (up_ok && !here_req) ? req_sel : '0;
        set_dn  = (dn_ok && !here_req) ? req_sel : '0;
        set_car = (in_ok && !here_req) ? req_sel : '0;
    end

    // Floor masks for the current floor and the floor being arrived at
    always_comb begin
        nxt_floor = (state == MOVE_DOWN) ? current_floor - 3'd1
                                         : current_floor + 3'd1;
        sel_cur = '0;
        sel_nxt = '0;
        gt_cur  = '0;
        lt_cur  = '0;
        gt_nxt  = '0;
        lt_nxt  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            sel_cur[i] = (3'(i) == current_floor);
            sel_nxt[i] = (3'(i) == nxt_floor);
            gt_cur[i]  = (3'(i) > current_floor);
            lt_cur[i]  = (3'(i) < current_floor);
            gt_nxt[i]  = (3'(i) > nxt_floor);
            lt_nxt[i]  = (3'(i) < nxt_floor);
        end
        here_cur  = |(pending & sel_cur);
        above_cur = |(pending & gt_cur);
        below_cur = |(pending & lt_cur);
        above_nxt = |(pending & gt_nxt);
        below_nxt = |(pending & lt_nxt);
        tick      = (timer == 32'd1);
        stop_up   = (|((car_calls | up_calls) & sel_nxt)) || !above_nxt;
        stop_dn   = (|((car_calls | dn_calls) & sel_nxt)) || !below_nxt;
        go_up     = above_cur && (dir || !below_cur);
        go_dn     = below_cur && (!dir || !above_cur);
    end

    // Calls served by this cycle's transition
    always_comb begin
        clr_up  = '0;
        clr_dn  = '0;
        clr_car = '0;
        unique case (state)
            IDLE: begin
                if (here_cur) begin
                    clr_up  = sel_cur;
                    clr_dn  = sel_cur;
                    clr_car = sel_cur;
                end
            end
            MOVE_UP: begin
                if (tick && stop_up) begin
                    clr_up  = sel_nxt;
                    clr_car = sel_nxt;
                    clr_dn  = above_nxt ? '0 : sel_nxt;
                end
            end
            MOVE_DOWN: begin
                if (tick && stop_dn) begin
                    clr_dn  = sel_nxt;
                    clr_car = sel_nxt;
                    clr_up  = below_nxt ? '0 : sel_nxt;
                end
            end
            DOOR_OPEN: begin
                if (tick && !here_req) begin
                    if (go_up) begin
                        clr_up  = sel_cur;
                        clr_car = sel_cur;
                    end else if (go_dn) begin
                        clr_dn  = sel_cur;
                        clr_car = sel_cur;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Call bitmaps, car position, direction, timer and SCAN state machine
    always_ff @(posedge clk or negedge resetBtn_n) begin
        if (!resetBtn_n) begin
            state         <= IDLE;
            dir           <= 1'b1;
            timer         <= '0;
            current_floor <= '0;
            up_calls      <= '0;
            dn_calls      <= '0;
            car_calls     <= '0;
        end else begin
            up_calls  <= (up_calls & ~clr_up) | set_up;
            dn_calls  <= (dn_calls & ~clr_dn) | set_dn;
            car_calls <= (car_calls & ~clr_car) | set_car;
            unique case (state)
                IDLE: begin
                    if (here_cur) begin
                        state <= DOOR_OPEN;
                        timer <= DOOR_LD;
                    end else if (above_cur) begin
                        state <= MOVE_UP;
                        dir   <= 1'b1;
                        timer <= MOVE_LD;
                    end else if (below_cur) begin
                        state <= MOVE_DOWN;
                        dir   <= 1'b0;
                        timer <= MOVE_LD;
                    end
                end
                MOVE_UP: begin
                    if (tick) begin
                        current_floor <= nxt_floor;
                        if (stop_up) begin
                            state <= DOOR_OPEN;
                            timer <= DOOR_LD;
                        end else begin
                            timer <= MOVE_LD;
                        end
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                MOVE_DOWN: begin
                    if (tick) begin
                        current_floor <= nxt_floor;
                        if (stop_dn) begin
                            state <= DOOR_OPEN;
                            timer <= DOOR_LD;
                        end else begin
                            timer <= MOVE_LD;
                        end
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                DOOR_OPEN: begin
                    if (here_req) begin
                        timer <= DOOR_LD;
                    end else if (tick) begin
                        if (go_up) begin
                            state <= MOVE_UP;
                            dir   <= 1'b1;
                            timer <= MOVE_LD;
                        end else if (go_dn) begin
                            state <= MOVE_DOWN;
                            dir   <= 1'b0;
                            timer <= MOVE_LD;
                        end else begin
                            state <= IDLE;
                            timer <= '0;
                        end
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
